// File: rtl/sensor_packet_framer.sv
// -----------------------------------------------------------------------------
// sensor_packet_framer
//
// Takes one-hot grants from the sensor priority arbiter and pops one sample
// from the granted sensor's FIFO. The sample is framed into a fixed 5-byte
// packet, which is streamed byte-by-byte to the host-link serializer.
//
// Packet: HEADER_BYTE, {seq[3:0], 2'b00, code[1:0]}, data[15:8], data[7:0],
//         csum = (id + data[15:8] + data[7:0]) mod 256
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   temp/hum/motion_grant         one-hot grants from the arbiter
//   temp/hum/motion_fifo_empty    FIFO empty flags
//   temp/hum/motion_rd_en         registered single-cycle FIFO pop strobes
//   temp/hum/motion_data          FIFO read data, valid the cycle after rd_en
//   tx_data, tx_valid, tx_ready   byte stream to the serializer
//   busy                          high whenever the framer is not idle
//   pkt_count                     packets fully sent (wraps)
//   grant_err                     sticky: more than one grant seen while idle
// -----------------------------------------------------------------------------
module sensor_packet_framer #(
  parameter int          DATA_WIDTH  = 16,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  temp_grant,
  input  logic                  hum_grant,
  input  logic                  motion_grant,
  input  logic                  temp_fifo_empty,
  input  logic                  hum_fifo_empty,
  input  logic                  motion_fifo_empty,
  output logic                  temp_rd_en,
  output logic                  hum_rd_en,
  output logic                  motion_rd_en,
  input  logic [DATA_WIDTH-1:0] temp_data,
  input  logic [DATA_WIDTH-1:0] hum_data,
  input  logic [DATA_WIDTH-1:0] motion_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [15:0]           pkt_count,
  output logic                  grant_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] POP     = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] S_HDR   = 3'd3;
  localparam logic [2:0] S_ID    = 3'd4;
  localparam logic [2:0] S_DH    = 3'd5;
  localparam logic [2:0] S_DL    = 3'd6;
  localparam logic [2:0] S_CSUM  = 3'd7;

  localparam logic [1:0] CODE_NONE   = 2'b00;
  localparam logic [1:0] CODE_TEMP   = 2'b01;
  localparam logic [1:0] CODE_HUM    = 2'b10;
  localparam logic [1:0] CODE_MOTION = 2'b11;

  logic [2:0]            state;
  logic [1:0]            code;
  logic [3:0]            seq;
  logic [DATA_WIDTH-1:0] sample;
  logic [7:0]            id_byte;
  logic [7:0]            csum;

  logic                  temp_elig, hum_elig, motion_elig, multi_grant;
  logic [1:0]            pick_code;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [7:0]            id_next;
  logic [7:0]            csum_next;
  logic                  handshake;

  assign temp_elig   = temp_grant   & ~temp_fifo_empty;
  assign hum_elig    = hum_grant    & ~hum_fifo_empty;
  assign motion_elig = motion_grant & ~motion_fifo_empty;

  // Checked on grants alone: an empty FIFO does not excuse a protocol error.
  assign multi_grant = (temp_grant & hum_grant) | (temp_grant & motion_grant) |
                       (hum_grant & motion_grant);

  assign busy      = (state != IDLE);
  assign handshake = tx_valid & tx_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pick_code = CODE_NONE;
    if (motion_elig)    pick_code = CODE_MOTION;
    else if (temp_elig) pick_code = CODE_TEMP;
    else if (hum_elig)  pick_code = CODE_HUM;
  end

  always_comb begin
    sel_data = '0;
    case (code)
      CODE_TEMP:   sel_data = temp_data;
      CODE_HUM:    sel_data = hum_data;
      CODE_MOTION: sel_data = motion_data;
      default:     sel_data = '0;
    endcase
  end

  // 8-bit sum keeps only the low byte, i.e. the mod-256 checksum.
  assign id_next   = {seq, 2'b00, code};
  assign csum_next = id_next + sel_data[15:8] + sel_data[7:0];

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      code         <= CODE_NONE;
      seq          <= '0;
      sample       <= '0;
      id_byte      <= '0;
      csum         <= '0;
      temp_rd_en   <= 1'b0;
      hum_rd_en    <= 1'b0;
      motion_rd_en <= 1'b0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      pkt_count    <= '0;
      grant_err    <= 1'b0;
    end else begin
      // Pop strobes are pulses: set only on the IDLE->POP transition.
      temp_rd_en   <= 1'b0;
      hum_rd_en    <= 1'b0;
      motion_rd_en <= 1'b0;

      case (state)
        IDLE: begin
          if (multi_grant) grant_err <= 1'b1;
          if (pick_code != CODE_NONE) begin
            code         <= pick_code;
            temp_rd_en   <= (pick_code == CODE_TEMP);
            hum_rd_en    <= (pick_code == CODE_HUM);
            motion_rd_en <= (pick_code == CODE_MOTION);
            state        <= POP;
          end
        end
        POP: state <= CAPTURE;
        CAPTURE: begin
          // FIFO data is valid this cycle, one cycle after the pop.
          sample   <= sel_data;
          id_byte  <= id_next;
          csum     <= csum_next;
          tx_data  <= HEADER_BYTE;
          tx_valid <= 1'b1;
          state    <= S_HDR;
        end
        S_HDR: if (handshake) begin
          tx_data <= id_byte;
          state   <= S_ID;
        end
        S_ID: if (handshake) begin
          tx_data <= sample[15:8];
          state   <= S_DH;
        end
        S_DH: if (handshake) begin
          tx_data <= sample[7:0];
          state   <= S_DL;
        end
        S_DL: if (handshake) begin
          tx_data <= csum;
          state   <= S_CSUM;
        end
        S_CSUM: if (handshake) begin
          tx_valid  <= 1'b0;
          tx_data   <= '0;
          seq       <= seq + 4'd1;
          pkt_count <= pkt_count + 16'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_packet_framer.sv
// -----------------------------------------------------------------------------
// tb_sensor_packet_framer
//
// Directed and randomized transactions against a packet-level reference model:
// each transaction the bench picks the winning sensor from grant/empty by
// priority (motion > temp > hum), builds the expected 5-byte packet from the
// sample and its own sequence counter, and compares every handshaken byte.
// -----------------------------------------------------------------------------
module tb_sensor_packet_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        temp_grant, hum_grant, motion_grant;
  logic        temp_fifo_empty, hum_fifo_empty, motion_fifo_empty;
  logic        temp_rd_en, hum_rd_en, motion_rd_en;
  logic [15:0] temp_data, hum_data, motion_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] pkt_count;
  logic        grant_err;

  sensor_packet_framer dut (
    .clk               (clk),
    .rst               (rst),
    .temp_grant        (temp_grant),
    .hum_grant         (hum_grant),
    .motion_grant      (motion_grant),
    .temp_fifo_empty   (temp_fifo_empty),
    .hum_fifo_empty    (hum_fifo_empty),
    .motion_fifo_empty (motion_fifo_empty),
    .temp_rd_en        (temp_rd_en),
    .hum_rd_en         (hum_rd_en),
    .motion_rd_en      (motion_rd_en),
    .temp_data         (temp_data),
    .hum_data          (hum_data),
    .motion_data       (motion_data),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .busy              (busy),
    .pkt_count         (pkt_count),
    .grant_err         (grant_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;

  // Reference model state
  logic [3:0] m_seq;
  int         m_pkts;
  logic       m_err;
  logic [7:0] last_pkt [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] rd_vec();
    return {motion_rd_en, hum_rd_en, temp_rd_en};
  endfunction

  task automatic model_reset();
    m_seq  = '0;
    m_pkts = 0;
    m_err  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rd_en"},     rd_vec(),  3'b000);
    check({tag, "_tx_valid"},  tx_valid,  1'b0);
    check({tag, "_tx_data"},   tx_data,   8'h00);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_pkt_count"}, pkt_count, 16'h0000);
    check({tag, "_grant_err"}, grant_err, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    {motion_grant, hum_grant, temp_grant} = 3'b000;
    tx_ready = 1'b0;
    @(negedge clk);
    model_reset();
    check_reset_state("reset");
    rst = 1'b0;
  endtask

  // One transaction: grants {motion,hum,temp} held for a single idle cycle.
  // stall is the percent chance tx_ready is low on a given cycle; abort_at >= 0
  // pulses rst while that byte index is being presented.
  task automatic txn(input logic [2:0] g, input logic [2:0] e,
                     input logic [15:0] dt, input logic [15:0] dh, input logic [15:0] dm,
                     input int stall, input int abort_at);
    logic [2:0]  elig;
    logic [1:0]  code;
    logic [2:0]  rd_exp;
    logic [15:0] s;
    logic [7:0]  expb [5];
    logic [7:0]  held;
    logic        stalled;
    int          k, cyc, last_cyc;

    @(negedge clk);
    temp_data = dt; hum_data = dh; motion_data = dm;
    {motion_fifo_empty, hum_fifo_empty, temp_fifo_empty} = e;
    {motion_grant, hum_grant, temp_grant} = g;
    tx_ready = 1'b0;
    if ($countones(g) > 1) m_err = 1'b1;
    elig = g & ~e;
    if (elig[2])      begin code = 2'b11; s = dm; rd_exp = 3'b100; end
    else if (elig[0]) begin code = 2'b01; s = dt; rd_exp = 3'b001; end
    else if (elig[1]) begin code = 2'b10; s = dh; rd_exp = 3'b010; end
    else              begin code = 2'b00; s = '0; rd_exp = 3'b000; end

    @(negedge clk);
    {motion_grant, hum_grant, temp_grant} = 3'b000;
    if (code == 2'b00) begin
      check("idle_no_rd_en", rd_vec(), 3'b000);
      check("idle_busy", busy, 1'b0);
      @(negedge clk);
      check("idle_no_rd_en2", rd_vec(), 3'b000);
      check("idle_grant_err", grant_err, m_err);
      return;
    end
    check("rd_en_pulse", rd_vec(), rd_exp);
    check("busy_pop", busy, 1'b1);

    @(negedge clk);
    check("rd_en_single", rd_vec(), 3'b000);
    check("valid_early", tx_valid, 1'b0);

    expb[0] = 8'hA5;
    expb[1] = {m_seq, 2'b00, code};
    expb[2] = s[15:8];
    expb[3] = s[7:0];
    expb[4] = expb[1] + expb[2] + expb[3];

    k = 0; cyc = 2; last_cyc = 0; stalled = 1'b0; held = '0;
    while (k < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) check("first_valid", tx_valid, 1'b1);
      if (abort_at == k && tx_valid) begin
        rst = 1'b1;
        tx_ready = 1'b0;
        @(negedge clk);
        model_reset();
        check("abort_valid", tx_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_pkt_count", pkt_count, 16'h0000);
        check("abort_rd_en", rd_vec(), 3'b000);
        rst = 1'b0;
        return;
      end
      if (stalled) begin
        check("stall_valid", tx_valid, 1'b1);
        check("stall_hold", tx_data, held);
      end
      tx_ready = ($urandom_range(0, 99) >= stall);
      stalled  = tx_valid && !tx_ready;
      held     = tx_data;
      if (tx_valid && tx_ready) begin
        check($sformatf("byte%0d", k), tx_data, expb[k]);
        last_pkt[k] = tx_data;
        k++;
        last_cyc = cyc;
      end
    end
    check("pkt_len", k, 5);
    if (stall == 0) check("latency", last_cyc, 7);
    m_seq  = m_seq + 4'd1;
    m_pkts = m_pkts + 1;

    @(negedge clk);
    tx_ready = 1'b0;
    check("end_valid", tx_valid, 1'b0);
    check("end_busy", busy, 1'b0);
    check("end_rd_en", rd_vec(), 3'b000);
    check("pkt_count", pkt_count, m_pkts[15:0]);
    check("grant_err", grant_err, m_err);
  endtask

  task automatic check_pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    check({tag, "_b0"}, last_pkt[0], b0);
    check({tag, "_b1"}, last_pkt[1], b1);
    check({tag, "_b2"}, last_pkt[2], b2);
    check({tag, "_b3"}, last_pkt[3], b3);
    check({tag, "_b4"}, last_pkt[4], b4);
  endtask

  initial begin
    rst = 1'b1;
    {motion_grant, hum_grant, temp_grant} = 3'b000;
    {motion_fifo_empty, hum_fifo_empty, temp_fifo_empty} = 3'b111;
    temp_data = '0; hum_data = '0; motion_data = '0;
    tx_ready = 1'b0;
    model_reset();
    foreach (last_pkt[i]) last_pkt[i] = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Single temp packet with a known sample.
    txn(3'b001, 3'b000, 16'h1234, 16'hBEEF, 16'hCAFE, 0, -1);
    check_pkt("temp", 8'hA5, 8'h01, 8'h12, 8'h34, 8'h47);

    // Checksum wrap: 0x03+0xFF+0xFF = 0x201 and 0x12+0x00+0xFF = 0x111.
    do_reset();
    txn(3'b100, 3'b000, 16'h1111, 16'h2222, 16'hFFFF, 0, -1);
    check_pkt("motion_wrap", 8'hA5, 8'h03, 8'hFF, 8'hFF, 8'h01);
    txn(3'b010, 3'b000, 16'h3333, 16'h00FF, 16'h4444, 0, -1);
    check_pkt("hum_wrap", 8'hA5, 8'h12, 8'h00, 8'hFF, 8'h11);

    // Random back-pressure during packets.
    for (int i = 0; i < 6; i++)
      txn(3'b001 << (i % 3), 3'b000, 16'($urandom), 16'($urandom), 16'($urandom), 50, -1);

    // Seventeen packets: seq field wraps back to 0 on the last one.
    do_reset();
    for (int i = 0; i < 17; i++)
      txn(3'b010, 3'b000, 16'($urandom), 16'($urandom), 16'($urandom), 0, -1);
    check("seq_wrap", last_pkt[1][7:4], 4'h0);
    check("count17", pkt_count, 16'd17);

    // Granted but empty: nothing popped. Then two grants: motion wins, error sticks.
    txn(3'b001, 3'b001, 16'h5555, 16'h6666, 16'h7777, 0, -1);
    txn(3'b101, 3'b000, 16'h5555, 16'h6666, 16'h7777, 0, -1);
    check("multi_code", last_pkt[1][1:0], 2'b11);
    check("multi_err", grant_err, 1'b1);
    txn(3'b010, 3'b000, 16'($urandom), 16'($urandom), 16'($urandom), 20, -1);
    check("err_sticky", grant_err, 1'b1);

    // Fully random grants, empties, data and back-pressure.
    for (int i = 0; i < 30; i++) begin
      txn(3'($urandom), 3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
          int'($urandom_range(0, 70)), -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset while the data-high byte is on the bus, then a fresh packet.
    txn(3'b010, 3'b000, 16'h0F0F, 16'hA1B2, 16'h0F0F, 0, 2);
    txn(3'b001, 3'b000, 16'h8001, 16'h0000, 16'h0000, 0, -1);
    check("post_abort_seq", last_pkt[1][7:4], 4'h0);
    check("post_abort_count", pkt_count, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
